// File: rtl/qracc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : qracc_seq_ctrl
// Description : Run sequencer for the QRAcc datapath. On START it snapshots
//               the output fmap size, strides and input bit count, then walks
//               bit-plane (innermost), x, y, offering one datapath step per
//               position. It waits for the datapath to drain and pulses done.
//               Optional macro QRACC_SEQ_PERF_EN adds busy/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================

package qracc_pkg;
  // CSR configuration image; only the fields used by the sequencer are listed
  typedef struct packed {
    logic [15:0] output_fmap_dimx;
    logic [15:0] output_fmap_dimy;
    logic [15:0] stride_x;
    logic [15:0] stride_y;
    logic [7:0]  n_input_bits_cfg;
  } qracc_config_t;
endpackage

module qracc_seq_ctrl
  import qracc_pkg::*;
#(
  parameter int DIM_W = 16,
  parameter int BIT_W = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [2:0]       trigger_i,
  input  logic             clear_i,
  input  qracc_config_t    cfg_i,
  output logic             step_valid_o,
  input  logic             step_ready_i,
  output logic [DIM_W-1:0] ofmap_x_o,
  output logic [DIM_W-1:0] ofmap_y_o,
  output logic [DIM_W-1:0] ifmap_x_o,
  output logic [DIM_W-1:0] ifmap_y_o,
  output logic [BIT_W-1:0] bit_idx_o,
  input  logic             dp_idle_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [3:0]       state_o,
  output logic [31:0]      perf_cycles_o,
  output logic [31:0]      perf_stalls_o
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_COMPUTE = 4'd1,
    ST_DRAIN   = 4'd2,
    ST_DONE    = 4'd3
  } state_t;

  localparam logic [2:0] TRIG_START = 3'd1;
  // Largest representable bit-plane index; larger bit counts clamp to it
  localparam logic [7:0] NB_CLAMP   = 8'((1 << BIT_W) - 1);

  state_t           state_q, state_d;
  logic [DIM_W-1:0] dimx_q, dimx_d, dimy_q, dimy_d;
  logic [DIM_W-1:0] stride_x_q, stride_x_d, stride_y_q, stride_y_d;
  logic [BIT_W-1:0] bit_last_q, bit_last_d;
  logic [DIM_W-1:0] x_q, x_d, y_q, y_d;
  logic [BIT_W-1:0] bit_q, bit_d;

  logic             start;
  logic [DIM_W-1:0] dimx_n, dimy_n;
  logic [7:0]       nb_m1;

  assign start  = (state_q == ST_IDLE) && (trigger_i == TRIG_START) && !clear_i;
  assign dimx_n = DIM_W'(cfg_i.output_fmap_dimx);
  assign dimy_n = DIM_W'(cfg_i.output_fmap_dimy);
  assign nb_m1  = (cfg_i.n_input_bits_cfg == 8'd0) ? 8'd0 : cfg_i.n_input_bits_cfg - 8'd1;

  // Next-state, snapshot capture and position walk; clear overrides all
  always_comb begin
    state_d    = state_q;
    dimx_d     = dimx_q;
    dimy_d     = dimy_q;
    stride_x_d = stride_x_q;
    stride_y_d = stride_y_q;
    bit_last_d = bit_last_q;
    x_d        = x_q;
    y_d        = y_q;
    bit_d      = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger_i == TRIG_START) begin
          dimx_d     = dimx_n;
          dimy_d     = dimy_n;
          stride_x_d = (cfg_i.stride_x == 16'd0) ? DIM_W'(1) : DIM_W'(cfg_i.stride_x);
          stride_y_d = (cfg_i.stride_y == 16'd0) ? DIM_W'(1) : DIM_W'(cfg_i.stride_y);
          bit_last_d = (nb_m1 > NB_CLAMP) ? {BIT_W{1'b1}} : BIT_W'(nb_m1);
          x_d        = '0;
          y_d        = '0;
          bit_d      = '0;
          state_d    = ((dimx_n == '0) || (dimy_n == '0)) ? ST_DONE : ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (step_ready_i) begin
          if (bit_q == bit_last_q) begin
            bit_d = '0;
            if (x_q == dimx_q - DIM_W'(1)) begin
              x_d = '0;
              if (y_q == dimy_q - DIM_W'(1)) begin
                y_d     = '0;
                state_d = ST_DRAIN;
              end else begin
                y_d = y_q + DIM_W'(1);
              end
            end else begin
              x_d = x_q + DIM_W'(1);
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (dp_idle_i) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) begin
      state_d = ST_IDLE;
      x_d     = '0;
      y_d     = '0;
      bit_d   = '0;
    end
  end

  // State, snapshot and position registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      dimx_q     <= '0;
      dimy_q     <= '0;
      stride_x_q <= '0;
      stride_y_q <= '0;
      bit_last_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      bit_q      <= '0;
    end else begin
      state_q    <= state_d;
      dimx_q     <= dimx_d;
      dimy_q     <= dimy_d;
      stride_x_q <= stride_x_d;
      stride_y_q <= stride_y_d;
      bit_last_q <= bit_last_d;
      x_q        <= x_d;
      y_q        <= y_d;
      bit_q      <= bit_d;
    end
  end

  assign step_valid_o = (state_q == ST_COMPUTE);
  assign busy_o       = (state_q == ST_COMPUTE) || (state_q == ST_DRAIN);
  assign done_o       = (state_q == ST_DONE);
  assign state_o      = state_q;
  assign ofmap_x_o    = x_q;
  assign ofmap_y_o    = y_q;
  assign bit_idx_o    = bit_q;
  assign ifmap_x_o    = DIM_W'(x_q * stride_x_q);
  assign ifmap_y_o    = DIM_W'(y_q * stride_y_q);

`ifdef QRACC_SEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;

  // Saturating busy/stall counters, restarted by each START
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (start) begin
      perf_cycles_d = '0;
      perf_stalls_d = '0;
    end else begin
      if (busy_o && (perf_cycles_q != 32'hFFFF_FFFF))
        perf_cycles_d = perf_cycles_q + 32'd1;
      if (step_valid_o && !step_ready_i && (perf_stalls_q != 32'hFFFF_FFFF))
        perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles_o = perf_cycles_q;
  assign perf_stalls_o = perf_stalls_q;
`else
  assign perf_cycles_o = 32'd0;
  assign perf_stalls_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_qracc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_qracc_seq_ctrl
// Description : Self-checking bench for qracc_seq_ctrl. Expected step tuples
//               are queued at START and popped as the DUT offers steps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qracc_seq_ctrl;
  import qracc_pkg::*;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [2:0]    trigger_i = 3'd0;
  logic          clear_i = 1'b0;
  qracc_config_t cfg_i = '0;
  logic          step_valid_o;
  logic          step_ready_i = 1'b1;
  logic [15:0]   ofmap_x_o, ofmap_y_o, ifmap_x_o, ifmap_y_o;
  logic [3:0]    bit_idx_o;
  logic          dp_idle_i = 1'b0;
  logic          busy_o, done_o;
  logic [3:0]    state_o;
  logic [31:0]   perf_cycles_o, perf_stalls_o;

  int total = 0;
  int bad   = 0;

  typedef struct { int x; int y; int b; int ix; int iy; } exp_t;
  exp_t q[$];

  qracc_seq_ctrl #(.DIM_W(16), .BIT_W(4)) dut (
    .clk(clk), .nrst(nrst), .trigger_i(trigger_i), .clear_i(clear_i), .cfg_i(cfg_i),
    .step_valid_o(step_valid_o), .step_ready_i(step_ready_i),
    .ofmap_x_o(ofmap_x_o), .ofmap_y_o(ofmap_y_o),
    .ifmap_x_o(ifmap_x_o), .ifmap_y_o(ifmap_y_o), .bit_idx_o(bit_idx_o),
    .dp_idle_i(dp_idle_i), .busy_o(busy_o), .done_o(done_o), .state_o(state_o),
    .perf_cycles_o(perf_cycles_o), .perf_stalls_o(perf_stalls_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int dx, input int dy, input int sx, input int sy, input int nb,
                     input int stall_at, input int stall_n, input int clr_at,
                     input bit mess, input bit rst_drain);
    int sxe, sye, nbe, n, stalled, guard, total_exp;
    exp_t e;
    sxe = (sx == 0) ? 1 : sx;
    sye = (sy == 0) ? 1 : sy;
    nbe = (nb == 0) ? 1 : nb;
    n = 0; stalled = 0; guard = 0;
    q.delete();
    for (int y = 0; y < dy; y++)
      for (int x = 0; x < dx; x++)
        for (int b = 0; b < nbe; b++) begin
          e.x = x; e.y = y; e.b = b;
          e.ix = (x * sxe) & 32'hFFFF;
          e.iy = (y * sye) & 32'hFFFF;
          q.push_back(e);
        end
    total_exp = q.size();
    cfg_i.output_fmap_dimx = 16'(dx);
    cfg_i.output_fmap_dimy = 16'(dy);
    cfg_i.stride_x         = 16'(sx);
    cfg_i.stride_y         = 16'(sy);
    cfg_i.n_input_bits_cfg = 8'(nb);
    dp_idle_i    = 1'b0;
    step_ready_i = 1'b1;
    trigger_i    = 3'd1;
    tick();
    trigger_i = 3'd0;
    if (total_exp == 0) begin
      check("zdim_state", 32'(state_o), 32'd3);
      check("zdim_done", 32'(done_o), 32'd1);
      check("zdim_valid", 32'(step_valid_o), 32'd0);
      tick();
      check("zdim_idle", 32'(state_o), 32'd0);
      check("zdim_done_end", 32'(done_o), 32'd0);
      return;
    end
    check("start_state", 32'(state_o), 32'd1);
    if (mess) begin
      cfg_i.output_fmap_dimx = 16'd9;
      cfg_i.output_fmap_dimy = 16'd7;
      cfg_i.n_input_bits_cfg = 8'd5;
      trigger_i = 3'd1;
    end
    while (state_o == 4'd1 && guard < 500) begin
      guard++;
      check("valid", 32'(step_valid_o), 32'd1);
      check("busy", 32'(busy_o), 32'd1);
      if (q.size() == 0) begin
        check("extra_step", 32'd1, 32'd0);
        break;
      end
      e = q[0];
      check("ofx", 32'(ofmap_x_o), 32'(e.x));
      check("ofy", 32'(ofmap_y_o), 32'(e.y));
      check("bit", 32'(bit_idx_o), 32'(e.b));
      check("ifx", 32'(ifmap_x_o), 32'(e.ix));
      check("ify", 32'(ifmap_y_o), 32'(e.iy));
      if (n == clr_at) begin
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clr_state", 32'(state_o), 32'd0);
        check("clr_busy", 32'(busy_o), 32'd0);
        check("clr_done", 32'(done_o), 32'd0);
        check("clr_valid", 32'(step_valid_o), 32'd0);
        check("clr_ofx", 32'(ofmap_x_o), 32'd0);
        tick();
        check("clr_done2", 32'(done_o), 32'd0);
        check("clr_state2", 32'(state_o), 32'd0);
        return;
      end
      if (n == stall_at && stalled < stall_n) begin
        step_ready_i = 1'b0;
        stalled++;
      end else begin
        step_ready_i = 1'b1;
        void'(q.pop_front());
        n++;
      end
      tick();
      trigger_i = 3'd0;
    end
    step_ready_i = 1'b1;
    if (guard >= 500) check("timeout", 32'(guard), 32'd0);
    check("steps", 32'(n), 32'(total_exp));
    check("q_empty", 32'(q.size()), 32'd0);
    check("drain_state", 32'(state_o), 32'd2);
    check("drain_valid", 32'(step_valid_o), 32'd0);
    check("drain_busy", 32'(busy_o), 32'd1);
    tick();
    check("drain_hold", 32'(state_o), 32'd2);
    if (rst_drain) begin
      #2 nrst = 1'b0;
      #1;
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_valid", 32'(step_valid_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_coord", 32'({ofmap_x_o, ofmap_y_o} | {ifmap_x_o, ifmap_y_o}), 32'd0);
      check("rst_perf", perf_cycles_o | perf_stalls_o, 32'd0);
      tick();
      nrst = 1'b1;
      tick();
      check("rst_idle", 32'(state_o), 32'd0);
      return;
    end
    tick();
    check("drain_hold2", 32'(state_o), 32'd2);
    dp_idle_i = 1'b1;
    tick();
    dp_idle_i = 1'b0;
    check("done_state", 32'(state_o), 32'd3);
    check("done_pulse", 32'(done_o), 32'd1);
    check("done_busy", 32'(busy_o), 32'd0);
    tick();
    check("end_state", 32'(state_o), 32'd0);
    check("end_done", 32'(done_o), 32'd0);
`ifdef QRACC_SEQ_PERF_EN
    check("perf_cycles", perf_cycles_o, 32'(total_exp + stall_n + 3));
    check("perf_stalls", perf_stalls_o, 32'(stall_n));
`else
    check("perf_cycles", perf_cycles_o, 32'd0);
    check("perf_stalls", perf_stalls_o, 32'd0);
`endif
  endtask

  initial begin
    #12;
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_valid", 32'(step_valid_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_coord", 32'({ofmap_x_o, ofmap_y_o}), 32'd0);
    check("reset_perf", perf_cycles_o | perf_stalls_o, 32'd0);
    nrst = 1'b1;
    tick();
    // dims, strides, bits, stall step/len, clear step, cfg churn, reset in drain
    run(2, 2, 1, 1, 2, -1, 0, -1, 1'b0, 1'b0);
    run(3, 1, 2, 1, 1, -1, 0, -1, 1'b0, 1'b0);
    run(2, 2, 1, 1, 2,  3, 5, -1, 1'b0, 1'b0);
    run(2, 2, 1, 1, 2, -1, 0,  4, 1'b0, 1'b0);
    run(3, 0, 1, 1, 2, -1, 0, -1, 1'b0, 1'b0);
    run(0, 2, 1, 1, 2, -1, 0, -1, 1'b0, 1'b0);
    run(2, 3, 0, 3, 0, -1, 0, -1, 1'b0, 1'b0);
    run(2, 2, 1, 1, 2, -1, 0, -1, 1'b0, 1'b1);
    run(2, 2, 1, 1, 3, -1, 0, -1, 1'b1, 1'b0);
    run(4, 2, 5, 7, 1,  0, 2, -1, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
